// File: rtl/rvv_backend_dispatch_bt_sched_pkg.sv
// Shared dispatch types for the byte-type scheduler.
// Holds uop info, generator result and tagged response bundle.
package rvv_backend_dispatch_bt_sched_pkg;

    localparam int NUM_DP_UOP = 4;
    localparam int BT_ID_W    = $clog2(NUM_DP_UOP);

    typedef struct packed {
        logic [7:0] vl;
        logic [7:0] vstart;
        logic [1:0] vsew;
        logic [2:0] uop_index;
    } UOP_INFO_t;

    typedef struct packed {
        logic [15:0] vd;
        logic [15:0] vs2;
    } UOP_OPN_BYTE_TYPE_t;

    typedef struct packed {
        logic [BT_ID_W-1:0] id;
        UOP_OPN_BYTE_TYPE_t bt;
    } BT_RSP_t;

endpackage

// File: rtl/rvv_backend_dispatch_bt_sched_if.sv
// Request / generator / response bundle of the byte-type scheduler.
// The scheduler uses slave; the dispatch side uses master.
interface rvv_backend_dispatch_bt_sched_if
    import rvv_backend_dispatch_bt_sched_pkg::*;
#(
    parameter int NUM_REQ = NUM_DP_UOP
);
    localparam int IW = $clog2(NUM_REQ);

    logic               flush;
    logic [NUM_REQ-1:0] req_valid;
    UOP_INFO_t          req_uop_info [NUM_REQ];
    logic [NUM_REQ-1:0] req_ready;
    UOP_INFO_t          gen_uop_info;
    UOP_OPN_BYTE_TYPE_t gen_byte_type;
    logic               rsp_valid;
    logic [IW-1:0]      rsp_id;
    UOP_OPN_BYTE_TYPE_t rsp_byte_type;
    logic               rsp_ready;
    logic               busy;

    modport slave (
        input  flush, req_valid, req_uop_info,
        input  gen_byte_type, rsp_ready,
        output req_ready, gen_uop_info,
        output rsp_valid, rsp_id, rsp_byte_type, busy
    );

    modport master (
        output flush, req_valid, req_uop_info,
        output gen_byte_type, rsp_ready,
        input  req_ready, gen_uop_info,
        input  rsp_valid, rsp_id, rsp_byte_type, busy
    );

endinterface

// File: rtl/rvv_backend_dispatch_bt_sched_rr_arbiter.sv
// Round-robin arbiter: first requester at or after ptr_i wins.
// Pure combinational; the owner keeps the pointer.
module rvv_backend_rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    int c;

    // Scan backwards so the nearest requester from ptr_i wins last.
    always_comb begin
        c     = 0;
        idx_o = '0;
        any_o = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            c = (int'(ptr_i) + i) % N;
            if (req_i[IW'(c)]) begin
                idx_o = IW'(c);
                any_o = 1'b1;
            end
        end
        gnt_o        = '0;
        gnt_o[idx_o] = any_o;
    end

endmodule

// File: rtl/rvv_backend_dispatch_bt_sched.sv
// Shares one byte-type generator among dispatch slots round-robin,
// queuing tagged results in a small response FIFO.
module rvv_backend_dispatch_bt_sched
    import rvv_backend_dispatch_bt_sched_pkg::*;
#(
    parameter int NUM_REQ   = NUM_DP_UOP,
    parameter int RSP_DEPTH = 2
) (
    input logic                          clk,
    input logic                          rst_n,
    rvv_backend_dispatch_bt_sched_if.slave bt_if
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int PW = $clog2(RSP_DEPTH);
    localparam int CW = PW + 1;

    logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]      gnt_idx;
    logic [NUM_REQ-1:0] gnt_oh;
    logic               gnt_any;
    BT_RSP_t            fifo_q [RSP_DEPTH];
    logic [PW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               space, push, pop;

    rvv_backend_rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_arb (
        .req_i (bt_if.req_valid),
        .ptr_i (rr_ptr_q),
        .gnt_o (gnt_oh),
        .idx_o (gnt_idx),
        .any_o (gnt_any)
    );

    assign pop   = (cnt_q != '0) & bt_if.rsp_ready;
    assign space = (cnt_q < CW'(RSP_DEPTH)) | pop;
    // rst_n gate keeps ready low while reset is held.
    assign push  = rst_n & gnt_any & space & ~bt_if.flush;
    assign cnt_d = cnt_q + CW'(push) - CW'(pop);

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (push) begin
            rr_ptr_d = (gnt_idx == IW'(NUM_REQ - 1)) ? '0
                     : gnt_idx + IW'(1);
        end
    end

    assign bt_if.req_ready     = push ? gnt_oh : '0;
    assign bt_if.gen_uop_info  = push ? bt_if.req_uop_info[gnt_idx] : '0;
    assign bt_if.rsp_valid     = (cnt_q != '0);
    assign bt_if.rsp_id        = IW'(fifo_q[rd_ptr_q].id);
    assign bt_if.rsp_byte_type = fifo_q[rd_ptr_q].bt;
    assign bt_if.busy          = (cnt_q != '0) | (|bt_if.req_valid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < RSP_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else if (bt_if.flush) begin
            rr_ptr_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q].id <= BT_ID_W'(gnt_idx);
                fifo_q[wr_ptr_q].bt <= bt_if.gen_byte_type;
            end
            wr_ptr_q <= wr_ptr_q + PW'(push);
            rd_ptr_q <= rd_ptr_q + PW'(pop);
            cnt_q    <= cnt_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: tb/tb_rvv_backend_dispatch_bt_sched.sv
// Directed and randomized checks of the byte-type scheduler,
// with a behavioural stand-in for the byte-type generator.
module tb_rvv_backend_dispatch_bt_sched;
    import rvv_backend_dispatch_bt_sched_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk  = 0;
    int   n_fail = 0;

    rvv_backend_dispatch_bt_sched_if #(.NUM_REQ(4)) bus ();

    rvv_backend_dispatch_bt_sched #(
        .NUM_REQ   (4),
        .RSP_DEPTH (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bt_if (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic UOP_OPN_BYTE_TYPE_t gen_model(UOP_INFO_t u);
        UOP_OPN_BYTE_TYPE_t r;
        r.vd  = {u.vl, u.vstart} ^ 16'h5a5a;
        r.vs2 = {u.vstart, u.vl} + {11'd0, u.vsew, u.uop_index};
        return r;
    endfunction

    function automatic UOP_INFO_t mk_info(int r, int s);
        UOP_INFO_t u;
        u.vl        = 8'(16 + r);
        u.vstart    = 8'(s);
        u.vsew      = 2'(r);
        u.uop_index = 3'(s + r);
        return u;
    endfunction

    always_comb bus.gen_byte_type = gen_model(bus.gen_uop_info);

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_flush();
        bus.flush     = 1'b1;
        bus.req_valid = '0;
        tick();
        bus.flush = 1'b0;
    endtask

    BT_RSP_t    exp_q[$];
    BT_RSP_t    e;
    int         seq   [4];
    int         waitc [4];
    logic [3:0] g;
    logic [3:0] gnt_prev;

    initial begin
        rst_n         = 1'b0;
        bus.flush     = 1'b0;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b0;
        for (int r = 0; r < 4; r++) bus.req_uop_info[r] = mk_info(r, 0);
        #1;
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'(1'b0));
        chk("rst_rsp_id", 64'(bus.rsp_id), 64'(2'd0));
        chk("rst_rsp_bt", 64'(bus.rsp_byte_type), 64'(32'd0));
        chk("rst_req_ready", 64'(bus.req_ready), 64'(4'd0));
        chk("rst_busy", 64'(bus.busy), 64'(1'b0));
        chk("rst_gen_info", 64'(bus.gen_uop_info), 64'(21'd0));
        #11 rst_n = 1'b1;
        tick();

        // single slot
        bus.req_valid = 4'b0010;
        bus.rsp_ready = 1'b1;
        #1;
        chk("t1_ready", 64'(bus.req_ready), 64'(4'b0010));
        chk("t1_gen_info", 64'(bus.gen_uop_info), 64'(mk_info(1, 0)));
        tick();
        bus.req_valid = '0;
        chk("t1_rsp_valid", 64'(bus.rsp_valid), 64'(1'b1));
        chk("t1_rsp_id", 64'(bus.rsp_id), 64'(2'd1));
        chk("t1_rsp_bt", 64'(bus.rsp_byte_type),
            64'(gen_model(mk_info(1, 0))));
        chk("t1_busy", 64'(bus.busy), 64'(1'b1));
        do_flush();
        chk("t1_flushed", 64'(bus.rsp_valid), 64'(1'b0));

        // fairness
        bus.req_valid = 4'b1111;
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("t2_ready", 64'(bus.req_ready), 64'(4'b0001 << (k % 4)));
            tick();
            chk("t2_rsp_valid", 64'(bus.rsp_valid), 64'(1'b1));
            chk("t2_rsp_id", 64'(bus.rsp_id), 64'(k % 4));
        end
        do_flush();

        // backpressure
        bus.rsp_ready = 1'b0;
        bus.req_valid = 4'b1111;
        #1 chk("t3_ready0", 64'(bus.req_ready), 64'(4'b0001));
        tick();
        #1 chk("t3_ready1", 64'(bus.req_ready), 64'(4'b0010));
        chk("t3_id_a", 64'(bus.rsp_id), 64'(2'd0));
        tick();
        #1 chk("t3_full_a", 64'(bus.req_ready), 64'(4'b0000));
        chk("t3_id_b", 64'(bus.rsp_id), 64'(2'd0));
        tick();
        #1 chk("t3_full_b", 64'(bus.req_ready), 64'(4'b0000));
        chk("t3_id_c", 64'(bus.rsp_id), 64'(2'd0));
        bus.rsp_ready = 1'b1;
        #1 chk("t3_pushpop", 64'(bus.req_ready), 64'(4'b0100));
        tick();
        chk("t3_id_d", 64'(bus.rsp_id), 64'(2'd1));
        chk("t3_valid_d", 64'(bus.rsp_valid), 64'(1'b1));

        // flush with two entries held
        bus.rsp_ready = 1'b0;
        bus.flush     = 1'b1;
        #1 chk("t4_ready_fl", 64'(bus.req_ready), 64'(4'b0000));
        tick();
        bus.flush = 1'b0;
        chk("t4_valid", 64'(bus.rsp_valid), 64'(1'b0));
        chk("t4_busy", 64'(bus.busy), 64'(1'b1));
        #1 chk("t4_first", 64'(bus.req_ready), 64'(4'b0001));
        tick();
        chk("t4_valid2", 64'(bus.rsp_valid), 64'(1'b1));
        chk("t4_id2", 64'(bus.rsp_id), 64'(2'd0));

        // async reset mid-stream
        rst_n = 1'b0;
        #1;
        chk("t5_valid", 64'(bus.rsp_valid), 64'(1'b0));
        chk("t5_ready", 64'(bus.req_ready), 64'(4'b0000));
        chk("t5_id", 64'(bus.rsp_id), 64'(2'd0));
        chk("t5_bt", 64'(bus.rsp_byte_type), 64'(32'd0));
        #1 rst_n = 1'b1;
        #1 chk("t5_resume", 64'(bus.req_ready), 64'(4'b0001));
        tick();
        chk("t5_valid2", 64'(bus.rsp_valid), 64'(1'b1));
        chk("t5_id2", 64'(bus.rsp_id), 64'(2'd0));
        do_flush();

        // random traffic against a scoreboard
        gnt_prev = '0;
        for (int r = 0; r < 4; r++) begin
            seq[r]   = 0;
            waitc[r] = 0;
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int r = 0; r < 4; r++) begin
                if (!bus.req_valid[r] || gnt_prev[r]) begin
                    if (gnt_prev[r]) seq[r]++;
                    bus.req_valid[r]    = ($urandom_range(0, 2) != 0);
                    bus.req_uop_info[r] = mk_info(r, seq[r]);
                end
            end
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("rnd_spurious", 64'(1'b1), 64'(1'b0));
                end else begin
                    e = exp_q.pop_front();
                    chk("rnd_id", 64'(bus.rsp_id), 64'(e.id));
                    chk("rnd_bt", 64'(bus.rsp_byte_type), 64'(e.bt));
                end
            end
            g = bus.req_ready;
            chk("rnd_onehot",
                64'($onehot0(g) && ((g & ~bus.req_valid) == 4'd0)),
                64'(1'b1));
            for (int r = 0; r < 4; r++) begin
                if (g[r]) begin
                    chk("rnd_fair", 64'(waitc[r] < 4), 64'(1'b1));
                    waitc[r] = 0;
                    e.id = 2'(r);
                    e.bt = gen_model(bus.req_uop_info[r]);
                    exp_q.push_back(e);
                end else if (bus.req_valid[r] && g != 4'd0) begin
                    waitc[r]++;
                end
            end
            gnt_prev = g;
            tick();
        end

        // drain
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            if (bus.rsp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("drain_spurious", 64'(1'b1), 64'(1'b0));
                end else begin
                    e = exp_q.pop_front();
                    chk("drain_id", 64'(bus.rsp_id), 64'(e.id));
                    chk("drain_bt", 64'(bus.rsp_byte_type), 64'(e.bt));
                end
            end
            tick();
        end
        chk("drain_empty", 64'(exp_q.size()), 64'(0));
        chk("drain_valid", 64'(bus.rsp_valid), 64'(1'b0));
        chk("drain_busy", 64'(bus.busy), 64'(1'b0));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
